call_panel: RTL and testbench
=============================

Name: call_panel

Overview:
- Request-initiator side of the elevator controller's floor-request interface.
- Latches asynchronous floor-button presses into a pending-call register.
- Issues each pending call exactly once, as a floor number, over a valid/ready handshake.
- Clears a call when the car reports arrival at that floor. Sits between the button inputs and the elevator controller's req_floor input.

Parameters:
- NUM_FLOORS, 8, number of floors and button inputs (floors 0..NUM_FLOORS-1).
- FLOOR_W, 4, width of floor-number buses; must satisfy 2**FLOOR_W >= NUM_FLOORS.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- btn  input  NUM_FLOORS  raw floor buttons, asynchronous, level-high while pressed.
- cur_floor  input  FLOOR_W  current car floor from the controller.
- arrive  input  1  one-cycle pulse: car has stopped at cur_floor and served it.
- req_floor  output  FLOOR_W  floor number offered to the controller.
- req_valid  output  1  req_floor holds a valid request.
- req_ready  input  1  controller accepts the request this cycle.
- pending  output  NUM_FLOORS  bit F set while floor F has an unserved call.
- busy  output  1  OR-reduction of pending.

Behaviour:
- Reset (async, rst=1): the following are all 0: sync stages, edge register, pending, sent, round-robin pointer ptr, req_floor, req_valid. State is IDLE. While rst is high, outputs hold these values.
- Button capture: two-flop synchronizer per bit (s1, s2), plus a previous register p.
  - A rise is s2 & ~p. A rise on bit F sets pending[F] on the same edge that updates p.
  - Latency: a button high before posedge N appears on pending at posedge N+2.
  - A held button sets pending only once. It can set pending again only after release and re-press.
- Clear: on arrive with cur_floor < NUM_FLOORS, pending[cur_floor] and sent[cur_floor] clear on that edge. If cur_floor >= NUM_FLOORS, arrive is ignored.
- Simultaneous rise and arrive for the same floor: the clear wins, so pending stays 0.
- Rise for a floor that is already pending: no effect, and no duplicate issue.
- Issue candidates are floors with pending & ~sent.
- FSM:
  - IDLE: if any candidate exists, go to SELECT; otherwise stay in IDLE.
  - SELECT (1 cycle):
    - Pick the first candidate at or above ptr, wrapping modulo NUM_FLOORS.
    - Load req_floor and set req_valid=1, then go to OFFER.
    - If the candidates vanished through an arrive this cycle, return to IDLE with req_valid=0.
  - OFFER:
    - req_valid=1, and req_floor is held stable until req_valid & req_ready at a posedge.
    - On that handshake, set sent[req_floor]; set ptr = req_floor+1, wrapping to 0 after NUM_FLOORS-1. Then req_valid=0 on that edge and go to IDLE.
    - An arrive that clears the offered floor during OFFER does not withdraw the offer; the handshake completes normally. sent is then set only if pending for that floor is still 1 after the clear, i.e. it is not set.
- Throughput: at most one request per 3 cycles (IDLE, SELECT, OFFER with ready already high).
- busy is combinational from pending.
- Reset asserted mid-OFFER: req_valid drops immediately (async), and all calls are lost.

Test Plan:
- Reset, then press btn[5] for 1 cycle with req_ready=1: pending=8'b0010_0000 at posedge 2. req_valid=1 with req_floor=5 two cycles later. Accepted, then req_valid=0 and no reissue.
- Press btn[2] and btn[6] together with ptr=0 and req_ready=1: issues 2 then 6. After that ptr=7, and a new press on btn[1] wraps and issues 1.
- Hold req_ready=0 for 10 cycles during OFFER of floor 3 and press btn[4]: req_floor stays 3 and req_valid stays 1 throughout. Raise ready, then floor 4 is issued next.
- After floor 5 is issued, pulse arrive with cur_floor=5: pending[5] and busy clear next edge. Re-press btn[5]: it is reissued.
- btn[2] rise coincides with arrive at cur_floor=2: pending[2] stays 0 and nothing is issued. arrive with cur_floor=9 leaves all state unchanged.
- Assert rst asynchronously mid-OFFER with req_floor=6: req_valid=0 and pending=0 immediately. After release, the FSM is in IDLE with no issue.

Source files
------------

// File: rtl/call_panel.sv
// Floor-call panel: synchronizes button presses into pending calls and offers
// each call once to the elevator controller over a valid/ready handshake.
module call_panel #(
   parameter int NUM_FLOORS = 8,
   parameter int FLOOR_W    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] btn,
   input  logic [FLOOR_W-1:0]    cur_floor,
   input  logic                  arrive,
   output logic [FLOOR_W-1:0]    req_floor,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, SELECT, OFFER} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [NUM_FLOORS-1:0] r_btn_s1, r_btn_s2, r_btn_p;
   logic [NUM_FLOORS-1:0] r_pending, r_sent;
   logic [FLOOR_W-1:0]    r_ptr, r_req_floor;
   logic                  r_req_valid;

   logic [NUM_FLOORS-1:0] w_rise, w_clr, w_hs_mask, w_cand;
   logic [NUM_FLOORS-1:0] w_pend_nxt, w_sent_nxt;
   logic                  w_hs, w_found, w_valid_nxt;
   logic [FLOOR_W-1:0]    w_pick, w_floor_nxt, w_ptr_nxt;

   assign w_rise = r_btn_s2 & ~r_btn_p;
   assign w_hs   = (r_state == OFFER) && r_req_valid && req_ready;

   // Out-of-range cur_floor matches no bit, so such an arrive is ignored.
   always_comb begin
      w_clr     = '0;
      w_hs_mask = '0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         w_clr[f]     = arrive && (cur_floor == FLOOR_W'(f));
         w_hs_mask[f] = w_hs && (r_req_floor == FLOOR_W'(f));
      end
   end

   assign w_pend_nxt = (r_pending | w_rise) & ~w_clr;
   assign w_sent_nxt = (r_sent | (w_hs_mask & w_pend_nxt)) & ~w_clr;
   assign w_cand     = r_pending & ~r_sent & ~w_clr;

   // Round-robin pick: rotate candidates so ptr sits at bit 0, take lowest set bit.
   always_comb begin : pick_blk
      logic [2*NUM_FLOORS-1:0] v_dbl;
      logic [NUM_FLOORS-1:0]   v_rot;
      logic [FLOOR_W:0]        v_sum;
      v_dbl   = {w_cand, w_cand} >> r_ptr;
      v_rot   = v_dbl[NUM_FLOORS-1:0];
      v_sum   = '0;
      w_found = 1'b0;
      w_pick  = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (!w_found && v_rot[i]) begin
            w_found = 1'b1;
            v_sum   = {1'b0, r_ptr} + (FLOOR_W+1)'(i);
            if (v_sum >= (FLOOR_W+1)'(NUM_FLOORS)) begin
               v_sum = v_sum - (FLOOR_W+1)'(NUM_FLOORS);
            end
            w_pick = v_sum[FLOOR_W-1:0];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = r_req_valid;
      w_floor_nxt = r_req_floor;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         IDLE: begin
            if (|(r_pending & ~r_sent)) begin
               w_state_nxt = SELECT;
            end
         end
         SELECT: begin
            if (w_found) begin
               w_floor_nxt = w_pick;
               w_valid_nxt = 1'b1;
               w_state_nxt = OFFER;
            end else begin
               w_valid_nxt = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         OFFER: begin
            if (w_hs) begin
               w_valid_nxt = 1'b0;
               w_ptr_nxt   = (r_req_floor == FLOOR_W'(NUM_FLOORS-1)) ? '0
                                                                     : r_req_floor + FLOOR_W'(1);
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_btn_s1    <= '0;
         r_btn_s2    <= '0;
         r_btn_p     <= '0;
         r_pending   <= '0;
         r_sent      <= '0;
         r_ptr       <= '0;
         r_req_floor <= '0;
         r_req_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_btn_s1    <= btn;
         r_btn_s2    <= r_btn_s1;
         r_btn_p     <= r_btn_s2;
         r_pending   <= w_pend_nxt;
         r_sent      <= w_sent_nxt;
         r_ptr       <= w_ptr_nxt;
         r_req_floor <= w_floor_nxt;
         r_req_valid <= w_valid_nxt;
      end
   end

   assign req_floor = r_req_floor;
   assign req_valid = r_req_valid;
   assign pending   = r_pending;
   assign busy      = |r_pending;

endmodule

// File: tb/tb_call_panel.sv
// Bench for call_panel: directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model of the call panel.
module tb_call_panel;
   localparam int N  = 8;
   localparam int FW = 4;

   logic          clk;
   logic          rst;
   logic [N-1:0]  btn;
   logic [FW-1:0] cur_floor;
   logic          arrive;
   logic [FW-1:0] req_floor;
   logic          req_valid;
   logic          req_ready;
   logic [N-1:0]  pending;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int offers[$];

   // Behavioural model: button history, call sets, and the offer in flight.
   logic [N-1:0] m_s1, m_s2, m_p, m_pend, m_sent;
   int           m_phase;   // 0 waiting, 1 choosing, 2 offering
   int           m_ptr, m_floor;
   logic         m_vld;

   call_panel #(.NUM_FLOORS(N), .FLOOR_W(FW)) dut (
      .clk(clk), .rst(rst), .btn(btn), .cur_floor(cur_floor), .arrive(arrive),
      .req_floor(req_floor), .req_valid(req_valid), .req_ready(req_ready),
      .pending(pending), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      m_s1 = '0; m_s2 = '0; m_p = '0; m_pend = '0; m_sent = '0;
      m_phase = 0; m_ptr = 0; m_floor = 0; m_vld = 1'b0;
   endfunction

   function automatic void model_edge();
      logic [N-1:0] rise, clr, cand, pend_n, sent_n;
      bit hit;
      if (rst) begin
         model_reset();
         return;
      end
      rise = m_s2 & ~m_p;
      clr  = '0;
      for (int f = 0; f < N; f++)
         if (arrive && int'(cur_floor) == f) clr[f] = 1'b1;
      pend_n = (m_pend | rise) & ~clr;
      sent_n = m_sent & ~clr;
      cand   = m_pend & ~m_sent & ~clr;
      case (m_phase)
         0: if ((m_pend & ~m_sent) != '0) m_phase = 1;
         1: begin
            hit = 1'b0;
            for (int i = 0; i < N; i++) begin
               int g;
               g = (m_ptr + i) % N;
               if (!hit && cand[g]) begin
                  hit = 1'b1;
                  m_floor = g;
               end
            end
            if (hit) begin m_vld = 1'b1; m_phase = 2; end
            else     begin m_vld = 1'b0; m_phase = 0; end
         end
         default: begin
            if (m_vld && req_ready) begin
               if (pend_n[m_floor]) sent_n[m_floor] = 1'b1;
               m_vld   = 1'b0;
               m_ptr   = (m_floor + 1) % N;
               m_phase = 0;
            end
         end
      endcase
      m_p = m_s2; m_s2 = m_s1; m_s1 = btn;
      m_pend = pend_n; m_sent = sent_n;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; btn = '0; arrive = 1'b0; cur_floor = '0;
      model_reset();
      tick(); tick();
      rst = 1'b0;
   endtask

   // Records each floor whose offer is accepted, up to 'want' or 'budget' cycles.
   task automatic collect(input int want, input int budget);
      offers.delete();
      for (int c = 0; c < budget && offers.size() < want; c++) begin
         if (req_valid === 1'b1 && req_ready === 1'b1) offers.push_back(int'(req_floor));
         tick();
      end
   endtask

   function automatic int off_at(input int k);
      return (k < offers.size()) ? offers[k] : -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; btn = '0; arrive = 1'b0; cur_floor = '0; req_ready = 1'b0;
      model_reset();
      tick(); tick();
      checks++;
      if (req_valid !== 1'b0 || req_floor !== 4'd0 || pending !== 8'h00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b floor=%0d pending=%b busy=%b, need all 0",
                  req_valid, req_floor, pending, busy);
      end
      btn = 8'hFF;
      tick(); tick(); tick();
      checks++;
      if (pending !== 8'h00 || req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: pending=%b valid=%b, need 0 while rst high", pending, req_valid);
      end
      btn = '0;
      rst = 1'b0;
      repeat (4) tick();
      checks++;
      if (pending !== 8'h00 || req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: pending=%b valid=%b, need 0", pending, req_valid);
      end
   endtask

   task automatic test_single();
      int bad;
      do_reset();
      req_ready = 1'b1;
      btn = 8'h20; tick(); btn = '0;
      tick();
      checks++;
      if (pending !== 8'h00) begin
         errors++;
         $display("FAIL single_latency_early: pending=%b, need 00000000", pending);
      end
      tick();
      checks++;
      if (pending !== 8'h20 || busy !== 1'b1 || req_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_pending: pending=%b busy=%b valid=%b, need 00100000 1 0",
                  pending, busy, req_valid);
      end
      tick();
      checks++;
      if (req_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_select: valid=%b, need 0", req_valid);
      end
      tick();
      checks++;
      if (req_valid !== 1'b1 || req_floor !== 4'd5) begin
         errors++;
         $display("FAIL single_offer: valid=%b floor=%0d, need 1 5", req_valid, req_floor);
      end
      bad = 0;
      repeat (8) begin
         tick();
         if (req_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || pending !== 8'h20) begin
         errors++;
         $display("FAIL single_no_reissue: valid-high cycles=%0d pending=%b, need 0 00100000",
                  bad, pending);
      end
   endtask

   task automatic test_pair_wrap();
      do_reset();
      req_ready = 1'b1;
      btn = 8'h44; tick(); btn = '0;
      collect(2, 30);
      checks++;
      if (offers.size() != 2 || off_at(0) != 2 || off_at(1) != 6) begin
         errors++;
         $display("FAIL pair_order: got n=%0d %0d,%0d need 2 then 6",
                  offers.size(), off_at(0), off_at(1));
      end
      repeat (3) tick();
      btn = 8'h82; tick(); btn = '0;
      collect(2, 30);
      checks++;
      if (offers.size() != 2 || off_at(0) != 7 || off_at(1) != 1) begin
         errors++;
         $display("FAIL wrap_order: got n=%0d %0d,%0d need 7 then 1",
                  offers.size(), off_at(0), off_at(1));
      end
   endtask

   task automatic test_backpressure();
      int bad;
      do_reset();
      req_ready = 1'b0;
      btn = 8'h08; tick(); btn = '0;
      for (int c = 0; c < 20 && req_valid !== 1'b1; c++) tick();
      checks++;
      if (req_valid !== 1'b1 || req_floor !== 4'd3) begin
         errors++;
         $display("FAIL bp_first_offer: valid=%b floor=%0d, need 1 3", req_valid, req_floor);
      end
      btn = 8'h10; tick(); btn = '0;
      bad = 0;
      repeat (10) begin
         tick();
         if (req_valid !== 1'b1 || req_floor !== 4'd3) bad++;
      end
      checks++;
      if (bad != 0 || pending !== 8'h18) begin
         errors++;
         $display("FAIL bp_hold: unstable cycles=%0d pending=%b, need 0 00011000", bad, pending);
      end
      req_ready = 1'b1;
      collect(2, 20);
      checks++;
      if (offers.size() != 2 || off_at(0) != 3 || off_at(1) != 4) begin
         errors++;
         $display("FAIL bp_order: got n=%0d %0d,%0d need 3 then 4",
                  offers.size(), off_at(0), off_at(1));
      end
   endtask

   task automatic test_arrive();
      do_reset();
      req_ready = 1'b1;
      btn = 8'h20; tick(); btn = '0;
      collect(1, 20);
      checks++;
      if (offers.size() != 1 || off_at(0) != 5 || pending !== 8'h20) begin
         errors++;
         $display("FAIL arrive_setup: n=%0d floor=%0d pending=%b, need 1 5 00100000",
                  offers.size(), off_at(0), pending);
      end
      arrive = 1'b1; cur_floor = 4'd5; tick(); arrive = 1'b0;
      checks++;
      if (pending !== 8'h00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL arrive_clear: pending=%b busy=%b, need 0 0", pending, busy);
      end
      btn = 8'h20; tick(); btn = '0;
      collect(1, 20);
      checks++;
      if (offers.size() != 1 || off_at(0) != 5) begin
         errors++;
         $display("FAIL arrive_repress: n=%0d floor=%0d, need 1 5", offers.size(), off_at(0));
      end
   endtask

   task automatic test_coincide();
      int bad;
      do_reset();
      req_ready = 1'b1;
      btn = 8'h04; tick(); btn = '0;
      tick();
      arrive = 1'b1; cur_floor = 4'd2; tick(); arrive = 1'b0;
      checks++;
      if (pending !== 8'h00) begin
         errors++;
         $display("FAIL coincide_clear: pending=%b, need 00000000", pending);
      end
      collect(1, 10);
      checks++;
      if (offers.size() != 0) begin
         errors++;
         $display("FAIL coincide_issue: issued n=%0d floor=%0d, need none", offers.size(), off_at(0));
      end
      req_ready = 1'b0;
      btn = 8'h08; tick(); btn = '0;
      for (int c = 0; c < 20 && req_valid !== 1'b1; c++) tick();
      arrive = 1'b1; cur_floor = 4'd9; tick();
      cur_floor = 4'd8; tick(); arrive = 1'b0;
      checks++;
      if (pending !== 8'h08 || req_valid !== 1'b1 || req_floor !== 4'd3) begin
         errors++;
         $display("FAIL arrive_out_of_range: pending=%b valid=%b floor=%0d, need 00001000 1 3",
                  pending, req_valid, req_floor);
      end
      arrive = 1'b1; cur_floor = 4'd3; tick(); arrive = 1'b0;
      checks++;
      if (pending !== 8'h00 || req_valid !== 1'b1 || req_floor !== 4'd3) begin
         errors++;
         $display("FAIL arrive_during_offer: pending=%b valid=%b floor=%0d, need 0 1 3",
                  pending, req_valid, req_floor);
      end
      req_ready = 1'b1; tick();
      bad = 0;
      repeat (6) begin
         if (req_valid !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL offer_after_clear: valid-high cycles=%0d, need 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      do_reset();
      req_ready = 1'b0;
      btn = 8'h40; tick(); btn = '0;
      for (int c = 0; c < 20 && req_valid !== 1'b1; c++) tick();
      checks++;
      if (req_valid !== 1'b1 || req_floor !== 4'd6) begin
         errors++;
         $display("FAIL midrst_setup: valid=%b floor=%0d, need 1 6", req_valid, req_floor);
      end
      #3 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (req_valid !== 1'b0 || pending !== 8'h00 || busy !== 1'b0 || req_floor !== 4'd0) begin
         errors++;
         $display("FAIL midrst_async: valid=%b pending=%b busy=%b floor=%0d, need all 0",
                  req_valid, pending, busy, req_floor);
      end
      tick(); tick();
      rst = 1'b0;
      bad = 0;
      repeat (6) begin
         tick();
         if (req_valid !== 1'b0 || pending !== 8'h00) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midrst_after: bad cycles=%0d, need 0", bad);
      end
   endtask

   task automatic test_random();
      do_reset();
      btn = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int f = 0; f < N; f++)
            if ($urandom_range(0, 7) == 0) btn[f] = ~btn[f];
         arrive    = ($urandom_range(0, 4) == 0);
         cur_floor = FW'($urandom_range(0, 10));
         req_ready = ($urandom_range(0, 1) == 1);
         tick();
         checks++;
         if (req_valid !== m_vld || req_floor !== FW'(m_floor)) begin
            errors++;
            $display("FAIL rand_req cyc %0d: valid=%b floor=%0d, need %b %0d",
                     cyc, req_valid, req_floor, m_vld, m_floor);
         end
         checks++;
         if (pending !== m_pend || busy !== (|m_pend)) begin
            errors++;
            $display("FAIL rand_pending cyc %0d: pending=%b busy=%b, need %b %b",
                     cyc, pending, busy, m_pend, |m_pend);
         end
      end
      btn = '0; arrive = 1'b0;
   endtask

   initial begin
      rst = 1'b1; btn = '0; arrive = 1'b0; cur_floor = '0; req_ready = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_pair_wrap();
      test_backpressure();
      test_arrive();
      test_coincide();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
